// File: rtl/ula_pkg.sv
// Shared definitions for the ula_multdiv multiply/divide unit.
//   - Funct codes as seen on the bus (MIPS-style encodings)
//   - ULAopcode: compact internal operation code derived from Funct
//   - FSM state type, also exported as a debug port by the top
//   - Funct decode helpers
package ula_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // Internal opcode: bit1 selects divide, bit0 selects signed.
  localparam logic [1:0] ULAOP_MULTU = 2'b00;
  localparam logic [1:0] ULAOP_MULT  = 2'b01;
  localparam logic [1:0] ULAOP_DIVU  = 2'b10;
  localparam logic [1:0] ULAOP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the four Funct codes that start an iterative operation.
  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // Maps Funct to ULAopcode; non-operation codes map to MULTU and are
  // filtered out by funct_valid.
  function automatic logic [1:0] funct_to_op(input logic [5:0] f);
    logic [1:0] op;
    op = ULAOP_MULTU;
    case (f)
      FUNCT_MULT: op = ULAOP_MULT;
      FUNCT_DIV:  op = ULAOP_DIV;
      FUNCT_DIVU: op = ULAOP_DIVU;
      default:    op = ULAOP_MULTU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ula_multdiv_if.sv
// Bus interface of the ula_multdiv unit.
// Handshake: the master raises start together with Funct/A/B; the request
// is accepted on a rising edge only while the unit is idle (busy=0 and
// done=0), otherwise it is silently dropped. There is no backpressure
// beyond that: completion is signalled by a single-cycle done pulse, and
// HI/LO/div_zero are valid in that cycle (HI/LO hold afterwards).
//   master: drives start, Funct, A, B; observes busy, done, div_zero,
//           HI, LO, Resultado
//   slave : the unit itself
interface ula_multdiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] Resultado;

  modport master (
    output start, Funct, A, B,
    input  busy, done, div_zero, HI, LO, Resultado
  );

  modport slave (
    input  start, Funct, A, B,
    output busy, done, div_zero, HI, LO, Resultado
  );
endinterface

// File: rtl/ula_passo_div.sv
// One combinational step of restoring division.
//   rem      : current partial remainder (always < divisor)
//   bit_in   : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this step
//   q_bit    : quotient bit produced by this step
module ula_passo_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  // Since rem < divisor, partial < 2*divisor, so a successful subtraction
  // always fits in WIDTH bits.
  assign partial  = {rem, bit_in};
  assign q_bit    = (partial >= {1'b0, divisor});
  assign diff     = partial[WIDTH-1:0] - divisor;
  assign rem_next = q_bit ? diff : partial[WIDTH-1:0];
endmodule

// File: rtl/ula_multdiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles.
// Divide by zero finishes after one busy cycle with HI=A, LO=all ones.
// Optional feature macro: ULA_SIGNED_EN -- when defined MULT/DIV are
// signed (magnitudes iterated, sign fixed on the edge entering DONE);
// when undefined MULT/DIV are identical to MULTU/DIVU.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   bus       : ula_multdiv_if slave (start/Funct/A/B in, busy/done/
//               div_zero/HI/LO/Resultado out)
//   dbg_state : current FSM state
module ula_multdiv
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  ula_multdiv_if.slave bus,
  output state_t       dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // work_hi: partial product high half / partial remainder
  // work_lo: multiplier shifting out / dividend shifting out, quotient in
  logic [WIDTH-1:0] work_hi, work_lo, operand_b, a_raw;
  logic [CW-1:0]    cnt;

  logic [1:0]       req_op;
  logic             req_valid, req_div;
  logic [WIDTH-1:0] a_in, b_in;

  assign req_op    = funct_to_op(bus.Funct);
  assign req_valid = funct_valid(bus.Funct);
  assign req_div   = (req_op == ULAOP_DIV) || (req_op == ULAOP_DIVU);

`ifdef ULA_SIGNED_EN
  logic req_signed, neg_q, neg_rem_q;
  assign req_signed = (req_op == ULAOP_MULT) || (req_op == ULAOP_DIV);
  assign a_in = (req_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_in = (req_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
`else
  assign a_in = bus.A;
  assign b_in = bus.B;
`endif

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, work_hi} + {1'b0, (work_lo[0] ? operand_b : '0)};
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], work_lo[WIDTH-1:1]};

  logic [WIDTH-1:0] div_rem_n, div_lo_n;
  logic             div_q;
  ula_passo_div #(.WIDTH(WIDTH)) u_passo (
    .rem      (work_hi),
    .bit_in   (work_lo[WIDTH-1]),
    .divisor  (operand_b),
    .rem_next (div_rem_n),
    .q_bit    (div_q)
  );
  assign div_lo_n = {work_lo[WIDTH-2:0], div_q};

  // Final results written on the last iteration edge.
  logic [WIDTH-1:0] fin_mul_hi, fin_mul_lo, fin_div_hi, fin_div_lo;
`ifdef ULA_SIGNED_EN
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  always_comb begin
    prod_mag   = {mul_hi_n, mul_lo_n};
    prod_fix   = neg_q ? -prod_mag : prod_mag;
    fin_mul_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_mul_lo = prod_fix[WIDTH-1:0];
    fin_div_lo = neg_q ? -div_lo_n : div_lo_n;
    // Remainder takes the sign of the dividend.
    fin_div_hi = neg_rem_q ? -div_rem_n : div_rem_n;
  end
`else
  assign fin_mul_hi = mul_hi_n;
  assign fin_mul_lo = mul_lo_n;
  assign fin_div_hi = div_rem_n;
  assign fin_div_lo = div_lo_n;
`endif

  logic last_step;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      operand_b <= '0;
      a_raw     <= '0;
      cnt       <= '0;
`ifdef ULA_SIGNED_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          dz_q   <= 1'b0;
          if (bus.start && req_valid) begin
            state     <= req_div ? ST_DIV : ST_MULT;
            busy_q    <= 1'b1;
            cnt       <= '0;
            work_hi   <= '0;
            work_lo   <= a_in;
            operand_b <= b_in;
            a_raw     <= bus.A;
`ifdef ULA_SIGNED_EN
            neg_q     <= req_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem_q <= req_signed && bus.A[WIDTH-1];
`endif
          end
        end
        ST_MULT: begin
          if (last_step) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            hi_q   <= fin_mul_hi;
            lo_q   <= fin_mul_lo;
            cnt    <= '0;
          end else begin
            work_hi <= mul_hi_n;
            work_lo <= mul_lo_n;
            cnt     <= cnt + 1'b1;
          end
        end
        ST_DIV: begin
          if (operand_b == '0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dz_q   <= 1'b1;
            hi_q   <= a_raw;
            lo_q   <= '1;
            cnt    <= '0;
          end else if (last_step) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            hi_q   <= fin_div_hi;
            lo_q   <= fin_div_lo;
            cnt    <= '0;
          end else begin
            work_hi <= div_rem_n;
            work_lo <= div_lo_n;
            cnt     <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          dz_q   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Resultado = '0;
    if (bus.Funct == FUNCT_MFHI)      bus.Resultado = hi_q;
    else if (bus.Funct == FUNCT_MFLO) bus.Resultado = lo_q;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_ula_multdiv.sv
// Testbench for ula_multdiv (WIDTH=32). Follows ULA_SIGNED_EN so the same
// bench works for both builds.
module tb_ula_multdiv;
  import ula_pkg::*;

  localparam int W = 32;
`ifdef ULA_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  always #5 clk = ~clk;

  ula_multdiv_if #(.WIDTH(W)) bus ();

  ula_multdiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q[$];   // {div_zero, HI, LO}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_div(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic [64:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic   sgn;
    longint sa, sb, q, r, p;
    sgn = SIGNED_EN && ((f == FUNCT_MULT) || (f == FUNCT_DIV));
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (!is_div(f)) begin
      p = sa * sb;
      return {1'b0, 64'(p)};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the unit idle. ignore_at>0 raises a second
  // start in that busy cycle, which must have no effect.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int ignore_at);
    logic [64:0] e;
    int lat_exp, cyc, busy_bad;
    exp_q.push_back(model(f, a, b));
    lat_exp   = (is_div(f) && b == 32'd0) ? 2 : W + 1;
    bus.start = 1'b1;
    bus.Funct = f;
    bus.A     = a;
    bus.B     = b;
    cyc = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == ignore_at);
      bus.Funct = (cyc == ignore_at) ? FUNCT_DIVU : 6'($urandom);
      bus.A     = $urandom;
      bus.B     = $urandom;
      if (!bus.done && !bus.busy) busy_bad++;
      if (bus.done && bus.busy) busy_bad++;
    end while (!bus.done && cyc < 80);
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(lat_exp));
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    e = exp_q.pop_front();
    check({tag, "_hi"}, 64'(bus.HI), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(bus.LO), 64'(e[31:0]));
    check({tag, "_dz"}, 64'(bus.div_zero), 64'(e[64]));
    bus.Funct = FUNCT_MFHI; #1;
    check({tag, "_mfhi"}, 64'(bus.Resultado), 64'(e[63:32]));
    bus.Funct = FUNCT_MFLO; #1;
    check({tag, "_mflo"}, 64'(bus.Resultado), 64'(e[31:0]));
    bus.Funct = 6'b100000; #1;
    check({tag, "_res_other"}, 64'(bus.Resultado), 64'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
  endtask

  logic [5:0] ops [4] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.Funct = 6'd0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dz", 64'(bus.div_zero), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
`ifdef ULA_SIGNED_EN
    run_op("mult_neg", FUNCT_MULT, 32'd7, 32'hFFFF_FFFD, 0);
    check("mult_neg_lo_const", 64'(bus.LO), 64'hFFFF_FFEB);
    check("mult_neg_hi_const", 64'(bus.HI), 64'hFFFF_FFFF);
    run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo_const", 64'(bus.LO), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(bus.HI), 64'hFFFF_FFFF);
`else
    run_op("mult_uns", FUNCT_MULT, 32'hFFFF_FFFF, 32'd2, 0);
    check("mult_uns_hi_const", 64'(bus.HI), 64'd1);
    check("mult_uns_lo_const", 64'(bus.LO), 64'hFFFF_FFFE);
`endif
    run_op("divu", FUNCT_DIVU, 32'd100, 32'd7, 0);
    check("divu_lo_const", 64'(bus.LO), 64'd14);
    check("divu_hi_const", 64'(bus.HI), 64'd2);
    run_op("div0", FUNCT_DIV, 32'd5, 32'd0, 0);
    check("div0_lo_const", 64'(bus.LO), 64'hFFFF_FFFF);
    run_op("multu_ign", FUNCT_MULTU, 32'd3, 32'd4, 10);
    check("multu_ign_lo_const", 64'(bus.LO), 64'd12);
    run_op("b2b", FUNCT_DIVU, 32'hDEAD_BEEF, 32'd3, 0);   // back-to-back
    run_op("minneg", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mulmax", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Reset mid-operation, with start asserted in the reset cycle
    bus.start = 1'b1; bus.Funct = FUNCT_MULTU;
    bus.A = 32'hFFFF_FFFF; bus.B = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.HI), 64'd0);
    check("abort_lo", 64'(bus.LO), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0; bus.start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 3)], ra, rb,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
